board_ram: RTL and testbench

// - Parametrised dual-read, single-write synchronous RAM holding the minesweeper board state.
// - Generalises the fixed block RAM: configurable width and depth, registered reads on both ports,
//   out-of-range protection, and a built-in clear sequencer that wipes the board on reset or request.
// - Sits between the game-logic FSM (port 1 read/write) and the VGA/display path (port 2 read-only).
//

---
 rtl/board_ram.sv | 168 ++++++++++++++++
 tb/tb_board_ram.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/board_ram.sv
// -----------------------------------------------------------------------------
// board_ram
//
// Dual-read, single-write synchronous RAM holding the minesweeper board.
// Port 1 (game-logic FSM) reads and writes; port 2 (display path) only reads.
// Both read ports are registered, with one clock of latency. Addresses at or
// beyond DEPTH read as zero and never write, so they do not alias onto real
// cells. A built-in sweep writes CLR_VAL to every cell after reset or on a clr
// request. While the sweep runs, busy is high, all accesses are ignored and
// both read ports return zero.
//
// Optional feature macro: BOARD_RAM_BYPASS_EN
//   defined   : an accepted port-1 write forwards its data to any port reading
//               the same address in that cycle (new-data read).
//   undefined : read-first; a same-cycle read returns the old contents.
//
// Ports
//   clk          in   1       single clock, all updates on posedge
//   resetn       in   1       synchronous active-low reset
//   clr          in   1       clear request, honoured only while busy=0
//   busy         out  1       high while the clear sweep runs
//   wEn          in   1       port 1 write enable
//   addr1        in   ADDR_W  port 1 read/write address
//   dataIn       in   DATA_W  port 1 write data
//   addr2        in   ADDR_W  port 2 read address
//   dataOut1     out  DATA_W  registered port 1 read data
//   dataOut2     out  DATA_W  registered port 2 read data
//   o_dbg_state  out  1       FSM state (0 = IDLE, 1 = CLEAR)
//
// Handshake: there is no valid/ready pair. A write is taken on any posedge
// where busy=0, wEn=1 and addr1<DEPTH. clr is taken on a posedge where busy=0.
// Read data for an address presented before edge N is valid after edge N.
// -----------------------------------------------------------------------------
module board_ram #(
    parameter int                 ADDR_W  = 12,
    parameter int                 DATA_W  = 32,
    parameter int                 DEPTH   = 4096,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    output logic              busy,
    input  logic              wEn,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] dataOut1,
    output logic [DATA_W-1:0] dataOut2,
    output logic              o_dbg_state
);

    // Physical index width. When DEPTH is below 2**ADDR_W the array is
    // indexed with the low bits only. The range check keeps upper addresses
    // from landing on real cells.
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_W  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_next;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout1;
    logic [DATA_W-1:0] r_dout2;

    logic              w_in1;
    logic              w_in2;
    logic [IDX_W-1:0]  w_idx1;
    logic [IDX_W-1:0]  w_idx2;
    logic              w_wr_ok;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_state_next = S_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            S_CLEAR: begin
                // The sweep finishes on the edge that writes the last cell.
                // busy is therefore high for exactly DEPTH edges.
                if (r_cnt == LAST_W) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign busy        = (r_state == S_CLEAR);
    assign o_dbg_state = r_state;

    // ---------------------------------------------------------- addressing
    assign w_in1   = ({1'b0, addr1} < DEPTH_W);
    assign w_in2   = ({1'b0, addr2} < DEPTH_W);
    assign w_idx1  = addr1[IDX_W-1:0];
    assign w_idx2  = addr2[IDX_W-1:0];
    assign w_wr_ok = (r_state == S_IDLE) && wEn && w_in1;

    // A single write port is shared by the sweep and port 1. The two sources
    // never collide because port-1 writes are only taken in IDLE.
    assign w_mem_we    = resetn && (busy || w_wr_ok);
    assign w_mem_addr  = busy ? r_cnt[IDX_W-1:0] : w_idx1;
    assign w_mem_wdata = busy ? CLR_VAL : dataIn;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // --------------------------------------------------------------- reads
    assign w_rd1 = w_in1 ? r_mem[w_idx1] : '0;
    assign w_rd2 = w_in2 ? r_mem[w_idx2] : '0;

    always_ff @(posedge clk) begin
        if (!resetn || busy) begin
            r_dout1 <= '0;
            r_dout2 <= '0;
        end else begin
`ifdef BOARD_RAM_BYPASS_EN
            // Port 1 always reads the address it is writing.
            r_dout1 <= w_wr_ok ? dataIn : w_rd1;
            r_dout2 <= (w_wr_ok && (addr2 == addr1)) ? dataIn : w_rd2;
`else
            r_dout1 <= w_rd1;
            r_dout2 <= w_rd2;
`endif
        end
    end

    assign dataOut1 = r_dout1;
    assign dataOut2 = r_dout2;

endmodule

// File: tb/tb_board_ram.sv
module tb_board_ram;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              clr;
    logic              busy;
    logic              wEn;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] dataIn;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] dataOut1;
    logic [DATA_W-1:0] dataOut2;
    logic              dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    logic [DATA_W-1:0] rdw_exp;

    board_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CLR_VAL(32'h0)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (clr),
        .busy       (busy),
        .wEn        (wEn),
        .addr1      (addr1),
        .dataIn     (dataIn),
        .addr2      (addr2),
        .dataOut1   (dataOut1),
        .dataOut2   (dataOut2),
        .o_dbg_state(dbg_state)
    );

    // ------------------------------------------------ clock
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wEn = 1'b1; addr1 = a; dataIn = d;
        tick();
        wEn = 1'b0;
    endtask

    // Counts edges until busy drops, bounded at 40.
    task automatic count_busy(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (busy && cnt < 40);
    endtask

    // ------------------------------------------------ directed sequence
    initial begin
        resetn = 1'b0; clr = 1'b0; wEn = 1'b0;
        addr1 = '0; addr2 = '0; dataIn = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_dout1", dataOut1, 32'h0);
        check("rst_dout2", dataOut2, 32'h0);

        // Reset release: busy for exactly DEPTH edges
        resetn = 1'b1;
        count_busy(n);
        check("rst_busy_len", n, DEPTH);
        check("rst_busy_low", {31'b0, busy}, 32'd0);

        // All cells cleared
        for (int a = 0; a < DEPTH; a++) begin
            addr1 = ADDR_W'(a); addr2 = ADDR_W'(DEPTH - 1 - a);
            tick();
            check("rst_clr_p1", dataOut1, 32'h0);
            check("rst_clr_p2", dataOut2, 32'h0);
        end

        // Basic write/read
        write(5'd5, 32'hDEADBEEF);
        addr2 = 5'd5; addr1 = 5'd0;
        tick();
        check("basic_p2", dataOut2, 32'hDEADBEEF);
        check("basic_p1_other", dataOut1, 32'h0);

        // Two different addresses at once
        write(5'd9, 32'h0000_0099);
        addr1 = 5'd5; addr2 = 5'd9;
        tick();
        check("dual_p1", dataOut1, 32'hDEADBEEF);
        check("dual_p2", dataOut2, 32'h0000_0099);

        // Read during write, same address
        write(5'd3, 32'h11);
`ifdef BOARD_RAM_BYPASS_EN
        rdw_exp = 32'h22;
`else
        rdw_exp = 32'h11;
`endif
        wEn = 1'b1; addr1 = 5'd3; addr2 = 5'd3; dataIn = 32'h22;
        tick();
        wEn = 1'b0;
        check("rdw_p1", dataOut1, rdw_exp);
        check("rdw_p2", dataOut2, rdw_exp);
        tick();
        check("rdw_after_p1", dataOut1, 32'h22);
        check("rdw_after_p2", dataOut2, 32'h22);

        // Out of range: no write, no alias onto cell 4, reads as zero
        write(5'd4, 32'h44);
        write(5'd20, 32'h0000FFFF);
        addr1 = 5'd4; addr2 = 5'd20;
        tick();
        check("oor_cell4", dataOut1, 32'h44);
        check("oor_read", dataOut2, 32'h0);

        // Clear request
        for (int a = 0; a < DEPTH; a++) write(ADDR_W'(a), 32'hA5A5A5A5);
        addr1 = 5'd7; addr2 = 5'd15;
        tick();
        check("fill_p1", dataOut1, 32'hA5A5A5A5);
        check("fill_p2", dataOut2, 32'hA5A5A5A5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy", {31'b0, busy}, 32'd1);
        n = 0;
        do begin
            // Writes during the sweep must be ignored; cell 3 is already
            // swept by cycle 12, so a write there would survive if taken.
            wEn    = (n == 4 || n == 12);
            addr1  = (n == 12) ? 5'd3 : 5'd7;
            dataIn = 32'h77;
            tick();
            n++;
            if (n == 6) check("clr_dout_zero", dataOut1, 32'h0);
        end while (busy && n < 40);
        wEn = 1'b0;
        check("clr_busy_len", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            addr1 = ADDR_W'(a); addr2 = ADDR_W'(a);
            tick();
            check("clr_p1", dataOut1, 32'h0);
            check("clr_p2", dataOut2, 32'h0);
        end

        // Reset in the middle of a sweep restarts it
        write(5'd12, 32'h12);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        resetn = 1'b0;
        tick();
        check("midrst_busy", {31'b0, busy}, 32'd1);
        check("midrst_dout", dataOut1, 32'h0);
        resetn = 1'b1;
        count_busy(n);
        check("midrst_busy_len", n, DEPTH);
        addr1 = 5'd12; addr2 = 5'd15;
        tick();
        check("midrst_cell12", dataOut1, 32'h0);
        check("midrst_cell15", dataOut2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
